mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter that responds on the data-memory bus side by side with `dmem`. It is the responder end of the same store/load path driven by the memory stage: it takes the same `read`/`writeb`/`addr`/`wdata` encoding that `dmem` consumes and returns `rdata` with the same one-cycle latency. Stored bytes are buffered in a FIFO and serialized 8N1 on `tx`. It gives software a console without stalling the pipeline.

---
 rtl/mmio_uart_tx_pkg.sv | 22 ++
 rtl/mmio_uart_tx_sync_fifo.sv | 55 +++++
 rtl/mmio_uart_tx.sv | 185 ++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// indices, STATUS bit positions and the transmit FSM state encoding.
package mmio_uart_tx_pkg;

  localparam logic [1:0] UART_REG_TXDATA  = 2'd0;
  localparam logic [1:0] UART_REG_STATUS  = 2'd1;
  localparam logic [1:0] UART_REG_DIVISOR = 2'd2;

  localparam int UART_STATUS_BUSY      = 0;
  localparam int UART_STATUS_FULL      = 1;
  localparam int UART_STATUS_EMPTY     = 2;
  localparam int UART_STATUS_OVERFLOW  = 3;
  localparam int UART_STATUS_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Synchronous FIFO with occupancy count. A push into a full FIFO is still
// accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter sitting beside dmem on the data bus:
// register decode, sticky overflow, divisor register and the serializer FSM.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int DIV_RESET  = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        read,
  input  logic [3:0]  writeb,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e            state, state_nx;
  logic [DIV_WIDTH-1:0] divisor, divisor_nx;
  logic [DIV_WIDTH-1:0] bit_cnt, bit_cnt_nx;
  logic [2:0]           bit_idx, bit_idx_nx;
  logic [7:0]           shift, shift_nx;
  logic                 tx_nx;
  logic                 bit_done;

  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [7:0]           fifo_dout;
  logic [CW-1:0]        fifo_count;

  logic                 overflow;
  logic                 txdata_wr;
  logic                 status_clr;
  logic                 push_drop;
  logic                 busy;
  logic [31:0]          rd_word;
  logic                 unused_bits;

  assign unused_bits = ^{wdata[31:16], writeb[3:2]};

  assign txdata_wr  = sel && writeb[0] && (addr == UART_REG_TXDATA);
  assign status_clr = sel && writeb[0] && (addr == UART_REG_STATUS) && wdata[3];
  assign push_drop  = txdata_wr && fifo_full && !fifo_pop;
  assign busy       = (state != TX_IDLE) || !fifo_empty;
  assign bit_done   = (bit_cnt == '0);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (txdata_wr),
    .din   (wdata[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    divisor_nx = divisor;
    if (sel && (addr == UART_REG_DIVISOR)) begin
      for (int i = 0; i < DIV_WIDTH && i < 16; i++) begin
        if (writeb[i/8]) divisor_nx[i] = wdata[i];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    case (addr)
      UART_REG_STATUS: begin
        rd_word[UART_STATUS_BUSY]              = busy;
        rd_word[UART_STATUS_FULL]              = fifo_full;
        rd_word[UART_STATUS_EMPTY]             = fifo_empty;
        rd_word[UART_STATUS_OVERFLOW]          = overflow;
        rd_word[UART_STATUS_COUNT_LSB +: CW]   = fifo_count;
      end
      UART_REG_DIVISOR: rd_word[DIV_WIDTH-1:0] = divisor;
      default:          rd_word = '0;
    endcase
  end

  // An overflow in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      divisor  <= DIV_WIDTH'(DIV_RESET);
      overflow <= 1'b0;
      rdata    <= '0;
    end else begin
      divisor <= divisor_nx;
      if (push_drop)       overflow <= 1'b1;
      else if (status_clr) overflow <= 1'b0;
      if (sel && read)     rdata <= rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= TX_IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_cnt_nx;
      bit_idx <= bit_idx_nx;
      shift   <= shift_nx;
      tx      <= tx_nx;
    end
  end

  // Every bit slot lasts DIVISOR+1 cycles; the counter reloads from the live
  // divisor at each boundary so a mid-frame change lands on the next bit.
  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    bit_idx_nx = bit_idx;
    shift_nx   = shift;
    fifo_pop   = 1'b0;
    case (state)
      TX_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_nx   = fifo_dout;
          bit_cnt_nx = divisor;
          state_nx   = TX_START;
        end
      end
      TX_START: begin
        if (bit_done) begin
          bit_cnt_nx = divisor;
          bit_idx_nx = '0;
          state_nx   = TX_DATA;
        end else begin
          bit_cnt_nx = bit_cnt - 1'b1;
        end
      end
      TX_DATA: begin
        if (bit_done) begin
          bit_cnt_nx = divisor;
          if (bit_idx == 3'd7) begin
            state_nx = TX_STOP;
          end else begin
            shift_nx   = shift >> 1;
            bit_idx_nx = bit_idx + 1'b1;
          end
        end else begin
          bit_cnt_nx = bit_cnt - 1'b1;
        end
      end
      TX_STOP: begin
        if (bit_done) begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            shift_nx   = fifo_dout;
            bit_cnt_nx = divisor;
            state_nx   = TX_START;
          end else begin
            state_nx = TX_IDLE;
          end
        end else begin
          bit_cnt_nx = bit_cnt - 1'b1;
        end
      end
      default: state_nx = TX_IDLE;
    endcase

    case (state_nx)
      TX_START: tx_nx = 1'b0;
      TX_DATA:  tx_nx = shift_nx[0];
      default:  tx_nx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: directed register accesses plus random
// frames compared against a slot-level model of the 8N1 serial waveform.
module tb_mmio_uart_tx;
  import mmio_uart_tx_pkg::*;

  typedef logic [7:0] byte_q_t[$];
  typedef bit         bit_q_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        read;
  logic [3:0]  writeb;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mmio_uart_tx #(
    .FIFO_DEPTH (8),
    .DIV_WIDTH  (16),
    .DIV_RESET  (434)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sel    (sel),
    .read   (read),
    .writeb (writeb),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .tx     (tx)
  );

  task automatic bus_idle();
    sel    = 1'b0;
    read   = 1'b0;
    writeb = 4'b0000;
    addr   = 2'd0;
    wdata  = 32'd0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    sel = 1'b1; read = 1'b0; writeb = be; addr = a; wdata = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    sel = 1'b1; read = 1'b1; writeb = 4'b0000; addr = a; wdata = 32'd0;
    @(negedge clk);
    d = rdata;
    bus_idle();
  endtask

  // Expected tx samples: one idle sample, then 10 slots per byte (start,
  // 8 data bits LSB first, stop), each lasting the divisor in force +1,
  // then two trailing idle samples.
  task automatic build_wave(input byte_q_t bytes, input int div, input int chg_slot,
                            input int new_div, output bit_q_t w);
    int slot;
    logic [9:0] frame;
    int dur;
    w = {};
    w.push_back(1'b1);
    slot = 0;
    foreach (bytes[b]) begin
      frame = {1'b1, bytes[b], 1'b0};
      for (int j = 0; j < 10; j++) begin
        dur = ((chg_slot >= 0 && slot >= chg_slot) ? new_div : div) + 1;
        for (int k = 0; k < dur; k++) w.push_back(frame[j]);
        slot++;
      end
    end
    w.push_back(1'b1);
    w.push_back(1'b1);
  endtask

  // Stores bytes on consecutive cycles (optionally a DIVISOR write at cycle
  // mid_c) while sampling tx once per cycle, then compares to the model.
  task automatic run_frames(input string tag, input byte_q_t bytes, input int div,
                            input int mid_c, input int mid_div, input int chg_slot);
    bit_q_t exp_w;
    bit_q_t got_w;
    int n;
    int mism;
    build_wave(bytes, div, chg_slot, mid_div, exp_w);
    n = bytes.size();
    got_w = {};
    for (int c = 0; c < exp_w.size(); c++) begin
      if (c < n) begin
        sel = 1'b1; read = 1'b0; writeb = 4'b0001; addr = UART_REG_TXDATA;
        wdata = {24'd0, bytes[c]};
      end else if (c == mid_c) begin
        sel = 1'b1; read = 1'b0; writeb = 4'b0011; addr = UART_REG_DIVISOR;
        wdata = mid_div;
      end else begin
        bus_idle();
      end
      @(negedge clk);
      got_w.push_back(tx);
    end
    bus_idle();
    mism = 0;
    foreach (exp_w[i]) if (got_w[i] !== exp_w[i]) mism++;
    check(tag, mism, 0);
  endtask

  initial begin
    logic [31:0] d;
    byte_q_t bq;
    int div;
    int nb;
    int zeros;

    bus_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx", {31'd0, tx}, 1);
    check("reset_rdata", rdata, 0);
    rst = 1'b0;

    read_reg(UART_REG_STATUS, d);  check("status_idle", d, 32'h4);
    read_reg(UART_REG_DIVISOR, d); check("divisor_reset", d, 434);
    repeat (2) @(negedge clk);
    check("rdata_hold", rdata, 434);
    read_reg(2'd3, d);             check("reserved_read", d, 0);
    read_reg(UART_REG_TXDATA, d);  check("txdata_read", d, 0);

    sel = 1'b0; writeb = 4'b0011; addr = UART_REG_DIVISOR; wdata = 32'd9;
    @(negedge clk);
    addr = UART_REG_TXDATA;
    @(negedge clk);
    bus_idle();
    read_reg(UART_REG_DIVISOR, d); check("unselected_div_write", d, 434);
    read_reg(UART_REG_STATUS, d);  check("unselected_tx_write", d, 32'h4);

    sel = 1'b1; read = 1'b1; writeb = 4'b0011; addr = UART_REG_DIVISOR; wdata = 32'd3;
    @(negedge clk);
    d = rdata;
    bus_idle();
    check("read_before_write", d, 434);
    read_reg(UART_REG_DIVISOR, d); check("divisor_written", d, 3);

    bq = {};
    bq.push_back(8'h55);
    run_frames("frame_55", bq, 3, -1, 0, -1);
    read_reg(UART_REG_STATUS, d);  check("busy_clear_55", d, 32'h4);

    bq = {};
    bq.push_back(8'h41);
    bq.push_back(8'h42);
    run_frames("back_to_back", bq, 3, -1, 0, -1);
    read_reg(UART_REG_STATUS, d);  check("busy_clear_b2b", d, 32'h4);

    bq = {};
    bq.push_back(8'($urandom));
    run_frames("divisor_mid_frame", bq, 3, 15, 7, 4);
    read_reg(UART_REG_DIVISOR, d); check("divisor_after_change", d, 7);

    for (int t = 0; t < 4; t++) begin
      div = $urandom_range(1, 3);
      write_reg(UART_REG_DIVISOR, div, 4'b0011);
      nb = $urandom_range(1, 3);
      bq = {};
      for (int i = 0; i < nb; i++) bq.push_back(8'($urandom));
      run_frames("random_frames", bq, div, -1, 0, -1);
      read_reg(UART_REG_STATUS, d); check("random_idle", d, 32'h4);
    end

    write_reg(UART_REG_DIVISOR, 1000, 4'b0011);
    for (int i = 0; i < 10; i++) write_reg(UART_REG_TXDATA, 32'h30 + i, 4'b0001);
    check("tx_in_start", {31'd0, tx}, 0);
    read_reg(UART_REG_STATUS, d);  check("status_overflow", d, 32'h80B);
    write_reg(UART_REG_STATUS, 32'h8, 4'b0001);
    read_reg(UART_REG_STATUS, d);  check("overflow_cleared", d, 32'h803);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    write_reg(UART_REG_DIVISOR, 3, 4'b0011);
    for (int i = 0; i < 4; i++) write_reg(UART_REG_TXDATA, 32'hA0 + i, 4'b0001);
    repeat (6) @(negedge clk);
    check("in_data_before_reset", {31'd0, tx}, {31'd0, 1'b1 ^ 1'b1 ^ 1'b0} | 32'(8'hA0 & 8'h1));
    rst = 1'b1;
    @(negedge clk);
    check("tx_after_reset", {31'd0, tx}, 1);
    rst = 1'b0;
    read_reg(UART_REG_STATUS, d);  check("status_after_reset", d, 32'h4);
    zeros = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) zeros++;
    end
    check("no_frames_after_reset", zeros, 0);
    read_reg(UART_REG_DIVISOR, d); check("divisor_after_reset", d, 434);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
